// File: rtl/square_wave_sequencer.sv
// Step-table driven square-wave sequencer: each entry is (half-period, duration)
// and is played in order through a half-period divider, optionally looping.
module square_wave_sequencer #(
    parameter  int DEPTH    = 8,
    parameter  int HALF_W   = 16,
    parameter  int DUR_W    = 16,
    parameter  int TICK_DIV = 100,
    localparam int AW       = $clog2(DEPTH),
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [HALF_W-1:0] wr_half,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [AW:0]       num_steps,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    output logic              square_wave,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

    state_t             r_state;
    logic [HALF_W-1:0]  r_tab_half [DEPTH];
    logic [DUR_W-1:0]   r_tab_dur  [DEPTH];
    logic [HALF_W-1:0]  r_half;
    logic [DUR_W-1:0]   r_dur;
    logic [HALF_W-1:0]  r_tic;
    logic [PW-1:0]      r_pre;
    logic [DUR_W-1:0]   r_tick;
    logic [AW-1:0]      r_last;
    logic               r_loop;
    logic               r_sq;
    logic               r_busy;
    logic               r_done;
    logic [AW-1:0]      r_idx;

    logic               w_pre_wrap;
    logic [DUR_W-1:0]   w_dur_last;
    logic               w_step_end;
    logic               w_tic_hit;
    logic               w_sq_next;
    logic [AW:0]        w_n_clamp;
    logic [AW:0]        w_n_minus1;

    // Table is storage only; it is not reset and may be written in any state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tab_half[wr_addr] <= wr_half;
            r_tab_dur[wr_addr]  <= wr_dur;
        end
    end

    // Subtractions are guarded so all-ones / zero fields never wrap the compares.
    assign w_pre_wrap = (r_pre == PW'(TICK_DIV - 1));
    assign w_dur_last = (r_dur == '0) ? '0 : r_dur - 1'b1;
    assign w_step_end = w_pre_wrap && (r_tick == w_dur_last);
    assign w_tic_hit  = (r_tic == r_half - 1'b1);
    assign w_sq_next  = (r_half == '0) ? 1'b0 : (w_tic_hit ? ~r_sq : r_sq);
    assign w_n_clamp  = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
    assign w_n_minus1 = w_n_clamp - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_half  <= '0;
            r_dur   <= '0;
            r_tic   <= '0;
            r_pre   <= '0;
            r_tick  <= '0;
            r_last  <= '0;
            r_loop  <= 1'b0;
            r_sq    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            if (stop && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_sq    <= 1'b0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!stop && start && num_steps != '0) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                            r_idx   <= '0;
                            r_last  <= w_n_minus1[AW-1:0];
                            r_loop  <= loop_en;
                        end
                    end
                    S_LOAD: begin
                        r_half  <= r_tab_half[r_idx];
                        r_dur   <= r_tab_dur[r_idx];
                        r_tic   <= '0;
                        r_pre   <= '0;
                        r_tick  <= '0;
                        r_sq    <= 1'b0;
                        r_state <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (r_half != '0)
                            r_tic <= w_tic_hit ? '0 : r_tic + 1'b1;
                        r_sq  <= w_sq_next;
                        r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
                        if (w_pre_wrap && !w_step_end)
                            r_tick <= r_tick + 1'b1;
                        if (w_step_end) begin
                            if (r_idx != r_last) begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= S_LOAD;
                            end else if (r_loop) begin
                                r_idx   <= '0;
                                r_state <= S_LOAD;
                            end else begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_sq    <= 1'b0;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign square_wave = r_sq;
    assign busy        = r_busy;
    assign done        = r_done;
    assign step_idx    = r_idx;
endmodule

// File: tb/tb_square_wave_sequencer.sv
// Bench for square_wave_sequencer: single-step vector table, directed corner
// sequences, and random step tables checked cycle-by-cycle against a trace model.
module tb_square_wave_sequencer;
    localparam int DEPTH = 8, HALF_W = 4, DUR_W = 4, TICK_DIV = 4, AW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [HALF_W-1:0] wr_half;
    logic [DUR_W-1:0]  wr_dur;
    logic [AW:0]       num_steps;
    logic              loop_en, start, stop;
    logic              square_wave, busy, done;
    logic [AW-1:0]     step_idx;

    square_wave_sequencer #(.DEPTH(DEPTH), .HALF_W(HALF_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_half(wr_half),
        .wr_dur(wr_dur), .num_steps(num_steps), .loop_en(loop_en), .start(start), .stop(stop),
        .square_wave(square_wave), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    typedef struct { int half; int dur; int busy_clks; int rises; } vec_t;
    typedef struct { bit b; bit d; bit s; int i; } obs_t;

    int   checks = 0, failures = 0;
    int   mh [DEPTH];
    int   md [DEPTH];
    obs_t exp_q [$];
    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int h, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_half = HALF_W'(h); wr_dur = DUR_W'(d);
        mh[a] = h; md[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_play(input int n, input bit lp);
        num_steps = (AW+1)'(n); loop_en = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic void push(bit b, bit d, bit s, int i);
        obs_t o;
        o.b = b; o.d = d; o.s = s; o.i = i;
        exp_q.push_back(o);
    endfunction

    // Expected observation after each edge from the start edge onward, derived
    // from step occupancy 1 + max(dur,1)*TICK_DIV and floor(j/half) toggles.
    function automatic void build(int n_req);
        int n, h, len;
        exp_q.delete();
        n = (n_req > DEPTH) ? DEPTH : n_req;
        push(1, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            h   = mh[k];
            len = ((md[k] == 0) ? 1 : md[k]) * TICK_DIV;
            push(1, 0, 0, k);
            for (int j = 1; j < len; j++)
                push(1, 0, (h != 0) ? bit'((j / h) % 2) : 1'b0, k);
            if (k < n - 1) push(1, 0, (h != 0) ? bit'((len / h) % 2) : 1'b0, k + 1);
            else           push(0, 1, 0, k);
        end
        push(0, 0, 0, n - 1);
    endfunction

    task automatic run_trace(input string name, input int n, output int busy_cnt);
        obs_t e;
        busy_cnt = 0;
        build(n);
        start_play(n, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            if (c > 0) tick();
            e = exp_q[c];
            checks++;
            if (busy !== e.b || done !== e.d || square_wave !== e.s || int'(step_idx) != e.i) begin
                failures++;
                $display("FAIL %s cyc %0d: got busy=%0b done=%0b sq=%0b idx=%0d expected busy=%0b done=%0b sq=%0b idx=%0d",
                         name, c, busy, done, square_wave, step_idx, e.b, e.d, e.s, e.i);
            end
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic wait_sq_high(input string name);
        int c = 0;
        while (square_wave !== 1'b1 && c < 100) begin tick(); c++; end
        chk({name, "_sq_high_seen"}, int'(square_wave === 1'b1), 1);
    endtask

    initial begin
        int bc, rises, cyc, errs, prev;
        vt[0] = '{2, 3, 13, 3};  vt[1] = '{1, 1, 5, 2};   vt[2] = '{0, 2, 9, 0};
        vt[3] = '{3, 1, 5, 1};   vt[4] = '{15, 15, 61, 2}; vt[5] = '{2, 0, 5, 1};
        vt[6] = '{5, 2, 9, 1};   vt[7] = '{1, 15, 61, 30};

        reset = 1'b1; wr_en = 0; wr_addr = 0; wr_half = 0; wr_dur = 0;
        num_steps = 0; loop_en = 0; start = 0; stop = 0;
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_sq", int'(square_wave), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_idx", int'(step_idx), 0);
        reset = 1'b0;
        tick();

        // Single-step vectors: busy length, rising-edge count, done pulse.
        for (int v = 0; v < 8; v++) begin
            wr(0, vt[v].half, vt[v].dur);
            start_play(1, 1'b0);
            bc = 0; rises = 0; cyc = 0; prev = 0;
            while (busy === 1'b1 && cyc < 200) begin
                bc++;
                if (square_wave === 1'b1 && prev == 0) rises++;
                prev = int'(square_wave === 1'b1);
                tick(); cyc++;
            end
            chk($sformatf("vec%0d_busy_clks", v), bc, vt[v].busy_clks);
            chk($sformatf("vec%0d_rises", v), rises, vt[v].rises);
            chk($sformatf("vec%0d_done", v), int'(done), 1);
            chk($sformatf("vec%0d_final_sq", v), int'(square_wave), 0);
            tick();
            chk($sformatf("vec%0d_done_clear", v), int'(done), 0);
        end

        // Three-step table including a rest step.
        wr(0, 1, 1); wr(1, 0, 2); wr(2, 3, 1);
        run_trace("multi3", 3, bc);
        chk("multi3_busy_clks", bc, 19);

        // Looping plays 0,1,0,1 with no done, then stop while output is high.
        wr(0, 2, 1); wr(1, 1, 1);
        start_play(2, 1'b1);
        errs = 0;
        for (int c = 0; c < 23; c++) begin
            if (c > 0) tick();
            if (int'(step_idx) != (c / 5) % 2 || done !== 1'b0 || busy !== 1'b1) errs++;
        end
        chk("loop_idx_seq_errs", errs, 0);
        wait_sq_high("loop");
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_sq", int'(square_wave), 0);
        chk("stop_idx", int'(step_idx), 0);
        chk("stop_done", int'(done), 0);
        tick();
        chk("stop_done_after", int'(done), 0);
        chk("stop_busy_after", int'(busy), 0);

        // num_steps = 0 and stop-over-start in idle are both ignored.
        start_play(0, 1'b0);
        tick();
        chk("nsteps0_busy", int'(busy), 0);
        stop = 1'b1; start_play(1, 1'b0); stop = 1'b0;
        chk("idle_stop_prio_busy", int'(busy), 0);

        // num_steps = DEPTH+1 is clamped to DEPTH.
        for (int a = 0; a < DEPTH; a++) wr(a, 1, 1);
        run_trace("clamp", DEPTH + 1, bc);
        chk("clamp_busy_clks", bc, 40);

        // Rewriting entry 0 mid-step only affects its next load.
        wr(0, 1, 1); wr(1, 0, 1);
        start_play(2, 1'b1);
        tick();                       // obs1
        wr(0, 3, 1);                  // obs2
        chk("rewrite_old_j1", int'(square_wave), 1);
        tick();
        chk("rewrite_old_j2", int'(square_wave), 0);
        repeat (9) tick();            // obs12: first PLAY edge of reloaded step 0
        chk("rewrite_idx", int'(step_idx), 0);
        chk("rewrite_new_j1", int'(square_wave), 0);
        tick(); tick();
        chk("rewrite_new_j3", int'(square_wave), 1);
        stop = 1'b1; tick(); stop = 1'b0;

        // Asynchronous reset while the output is high.
        wr(0, 2, 3);
        start_play(1, 1'b0);
        wait_sq_high("areset");
        #2 reset = 1'b1;
        #1;
        chk("areset_sq", int'(square_wave), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_idx", int'(step_idx), 0);
        tick();
        reset = 1'b0;
        tick();
        run_trace("after_reset", 1, bc);
        chk("after_reset_busy_clks", bc, 13);

        // Random tables and step counts against the trace model.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++)
                wr(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
            run_trace($sformatf("rand%0d", r), int'($urandom_range(1, DEPTH + 1)), bc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
